serial_output: RTL and testbench

Stream-to-UART transmitter fed by the 32-bit `output_rs232_tx` stream of `user_design`. Accepts one word per stb/ack transfer, sends its low byte on a serial line as an 8N1 frame (LSB first), and holds off further transfers until the frame is finished. Sits between `user_design` and the board-level RS-232 TX pin.

---
 rtl/serial_output.sv | 149 ++++++++++++++
 tb/tb_serial_output.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_output.sv
// rtl/serial_output.sv - stream-to-UART 8N1 transmitter
//
// Accepts one 32-bit word per stb/ack transfer and sends its low byte LSB
// first as an 8N1 frame. Further transfers are held off until the frame ends.
//
// Ports:
//   clk           in   1  rising-edge clock
//   rst           in   1  asynchronous active-high reset
//   input_tx      in  32  data word, only [7:0] is transmitted
//   input_tx_stb  in   1  producer strobe, held with stable data until transfer
//   input_tx_ack  out  1  registered acknowledge, high only in IDLE
//   tx            out  1  serial line, idle high
//   tx_busy       out  1  high while a frame is in progress

module serial_output #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_tx,
  input  logic        input_tx_stb,
  output logic        input_tx_ack,
  output logic        tx,
  output logic        tx_busy
);

  localparam int DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW      = $clog2(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  generate
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("serial_output: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [2:0]      r_idx, w_idx_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            r_tx, w_tx_n;
  logic            r_ack, w_ack_n;
  logic            r_busy, w_busy_n;
  logic            w_bit_end;
  logic            w_unused_upper;

  // Upper word bits are deliberately not transmitted.
  assign w_unused_upper = ^input_tx[31:8];

  assign w_bit_end    = (r_cnt == LAST);
  assign input_tx_ack = r_ack;
  assign tx           = r_tx;
  assign tx_busy      = r_busy;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_ack_n   = r_ack;
    w_busy_n  = r_busy;
    case (r_state)
      S_IDLE: begin
        // ack comes up on the first edge after reset and stays up while idle
        w_cnt_n  = '0;
        w_tx_n   = 1'b1;
        w_ack_n  = 1'b1;
        w_busy_n = 1'b0;
        if (input_tx_stb && r_ack) begin
          w_shift_n = input_tx[7:0];
          w_ack_n   = 1'b0;
          w_tx_n    = 1'b0;
          w_busy_n  = 1'b1;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_idx_n   = '0;
          w_tx_n    = r_shift[0];
          w_state_n = S_DATA;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          w_idx_n   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_tx_n    = 1'b1;
            w_state_n = S_STOP;
          end else begin
            // next bit is what shift[0] becomes after this shift
            w_tx_n = r_shift[1];
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_tx_n    = 1'b1;
          w_ack_n   = 1'b1;
          w_busy_n  = 1'b0;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      r_ack   <= w_ack_n;
      r_busy  <= w_busy_n;
    end
  end

endmodule

// File: tb/tb_serial_output.sv
// tb/tb_serial_output.sv - self-checking bench for serial_output

module tb_serial_output;

  localparam int DIV = 10;

  logic        clk;
  logic        rst;
  logic [31:0] input_tx;
  logic        input_tx_stb;
  logic        input_tx_ack;
  logic        tx;
  logic        tx_busy;

  int total;
  int bad;
  int cyc;
  int n_xfer;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs [4];
  logic [7:0] exp_q [$];

  serial_output #(
    .CLOCK_FREQUENCY(1000),
    .BAUD_RATE(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .input_tx(input_tx),
    .input_tx_stb(input_tx_stb),
    .input_tx_ack(input_tx_ack),
    .tx(tx),
    .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // transfer rule observed directly on the line: stb and ack both high at an edge
  always @(posedge clk) begin
    if (!rst && input_tx_stb === 1'b1 && input_tx_ack === 1'b1) n_xfer++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic accept(input string name, output int waited, output int start);
    waited = 0;
    do begin
      step();
      waited++;
    end while (tx_busy !== 1'b1 && waited < 30 * DIV);
    start = cyc;
    check({name, "_accept"}, 32'(tx_busy), 32'd1);
  endtask

  // Expected line: start 0, eight data bits LSB first, stop 1, each DIV cycles.
  task automatic check_frame(input string name, input logic [7:0] exp_byte,
                             input int raise_at, input logic [31:0] next_word);
    logic [9:0] frame;
    logic [7:0] dec;
    int wave_err;
    frame = {1'b1, exp_byte, 1'b0};
    dec = 8'h00;
    wave_err = 0;
    for (int j = 0; j < 10 * DIV; j++) begin
      if (j > 0) step();
      if (j == 0) input_tx_stb = 1'b0;
      if (j == raise_at) begin
        input_tx = next_word;
        input_tx_stb = 1'b1;
      end
      if (tx !== frame[4'(j / DIV)] || input_tx_ack !== 1'b0 || tx_busy !== 1'b1) wave_err++;
      if (j >= DIV && j < 9 * DIV && (j % DIV) == DIV / 2) dec[3'((j / DIV) - 1)] = tx;
    end
    step();
    check({name, "_wave"}, 32'(wave_err), 32'd0);
    check({name, "_byte"}, 32'(dec), 32'(exp_byte));
    check({name, "_idle"}, 32'({tx, input_tx_ack, tx_busy}), 32'h6);
  endtask

  initial begin
    int waited, s_prev, s_now, err, xf0, raise_at;
    logic [31:0] w, nw;
    bit pending;

    total = 0; bad = 0; cyc = 0; n_xfer = 0;
    vecs[0] = '{32'h12345655, 8'h55};
    vecs[1] = '{32'hDEADBE00, 8'h00};
    vecs[2] = '{32'h000000FF, 8'hFF};
    vecs[3] = '{32'h7E5A3C81, 8'h81};

    rst = 1'b1;
    input_tx = 32'h0;
    input_tx_stb = 1'b0;

    // reset and release with stb low
    repeat (3) step();
    check("in_reset", 32'({tx, input_tx_ack, tx_busy}), 32'h4);
    rst = 1'b0;
    #1;
    check("release_cycle0", 32'({tx, input_tx_ack, tx_busy}), 32'h4);
    step();
    check("release_cycle1", 32'({tx, input_tx_ack, tx_busy}), 32'h6);
    err = 0;
    repeat (100) begin
      step();
      if ({tx, input_tx_ack, tx_busy} !== 3'b110) err++;
    end
    check("idle_100", 32'(err), 32'd0);

    // table: all vectors sent back to back with stb held high throughout
    xf0 = n_xfer;
    input_tx = vecs[0].word;
    input_tx_stb = 1'b1;
    accept("vec0", waited, s_prev);
    check("vec0_latency", 32'(waited), 32'd1);
    for (int i = 0; i < 4; i++) begin
      nw = (i < 3) ? vecs[(i + 1) % 4].word : 32'h0;
      check_frame($sformatf("vec%0d", i), vecs[i].exp_byte, (i < 3) ? 0 : -1, nw);
      if (i < 3) begin
        accept($sformatf("vec%0d", i + 1), waited, s_now);
        check($sformatf("vec%0d_period", i + 1), 32'(s_now - s_prev), 32'(10 * DIV + 1));
        s_prev = s_now;
      end
    end
    check("b2b_xfers", 32'(n_xfer - xf0), 32'd4);

    // stb raised at cycle 35 of a frame waits for the frame to end
    input_tx = 32'h000000C3;
    input_tx_stb = 1'b1;
    accept("mid_a", waited, s_prev);
    check_frame("mid_a", 8'hC3, 35, 32'hFFFF0E96);
    accept("mid_b", waited, s_now);
    check("mid_b_at101", 32'(s_now - s_prev), 32'(10 * DIV + 1));
    check_frame("mid_b", 8'h96, -1, 32'h0);

    // asynchronous reset at cycle 47 of an 0xA5 frame
    input_tx = 32'h000000A5;
    input_tx_stb = 1'b1;
    accept("rst_frame", waited, s_prev);
    input_tx_stb = 1'b0;
    repeat (47) step();
    check("pre_rst_bit", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst", 32'({tx, input_tx_ack, tx_busy}), 32'h4);
    err = 0;
    repeat (3) begin
      step();
      if ({tx, input_tx_ack, tx_busy} !== 3'b100) err++;
    end
    check("rst_hold", 32'(err), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_ack", 32'({tx, input_tx_ack, tx_busy}), 32'h6);
    input_tx = 32'h0000003C;
    input_tx_stb = 1'b1;
    accept("after_rst", waited, s_now);
    check("after_rst_latency", 32'(waited), 32'd1);
    check_frame("after_rst", 8'h3C, -1, 32'h0);

    // randomized words, gaps and mid-frame strobes against a queue of expected bytes
    pending = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!pending) begin
        err = 0;
        repeat ($urandom_range(0, 12)) begin
          step();
          if ({tx, input_tx_ack, tx_busy} !== 3'b110) err++;
        end
        check($sformatf("rnd%0d_gap", i), 32'(err), 32'd0);
        w = $urandom;
        input_tx = w;
        input_tx_stb = 1'b1;
        exp_q.push_back(w[7:0]);
      end
      accept($sformatf("rnd%0d", i), waited, s_now);
      check($sformatf("rnd%0d_latency", i), 32'(waited), 32'd1);
      raise_at = -1;
      nw = 32'h0;
      if (i < 7 && $urandom_range(0, 1) == 1) begin
        raise_at = $urandom_range(0, 10 * DIV - 1);
        nw = $urandom;
        exp_q.push_back(nw[7:0]);
      end
      pending = (raise_at >= 0);
      check_frame($sformatf("rnd%0d", i), exp_q.pop_front(), raise_at, nw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
